// File: rtl/mem_64kib.sv
// Single-port word-granular RAM with a registered read port and a read-valid pulse.
// Byte addresses above the array window are dropped on write and read as zero.
module mem_64kib #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter string       INIT_FILE   = ""
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              read_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] d_o,
  output logic              ready_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              unused_addr_bits;

  logic [DATA_W-1:0] d_o_d, d_o_q;
  logic              ready_o_d, ready_o_q;

  assign idx              = addr_i[IDX_W+1:2];
  assign in_range         = (addr_i[ADDR_W-1:IDX_W+2] == '0);
  assign unused_addr_bits = ^addr_i[1:0];

  // Power-up contents: zeros.
  initial begin
    mem = '{default: '0};
  end

  // The array is not reset; a write sampled while reset is low is discarded.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !read_en_i && in_range) mem[idx] <= d_i;
  end

  always_comb begin
    d_o_d     = d_o_q;
    ready_o_d = 1'b0;
    if (read_en_i) begin
      ready_o_d = 1'b1;
      d_o_d     = in_range ? mem[idx] : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_o_q     <= '0;
      ready_o_q <= 1'b0;
    end else begin
      d_o_q     <= d_o_d;
      ready_o_q <= ready_o_d;
    end
  end

  assign d_o     = d_o_q;
  assign ready_o = ready_o_q;

endmodule

// File: tb/tb_mem_64kib.sv
// Directed bench for mem_64kib: reference array plus a queue of expected read data
// pushed at request time and popped when the registered result appears.
module tb_mem_64kib;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        read_en_i;
  logic [31:0] addr_i;
  logic [31:0] d_i;
  logic [31:0] d_o;
  logic        ready_o;

  mem_64kib #(
    .DATA_W     (32),
    .ADDR_W     (32),
    .DEPTH_WORDS(16384),
    .INIT_FILE  ("")
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .read_en_i(read_en_i),
    .addr_i   (addr_i),
    .d_i      (d_i),
    .d_o      (d_o),
    .ready_o  (ready_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [31:0] model [int unsigned];
  logic [31:0] exp_q [$];
  logic [31:0] exp_d = 32'h0;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int unsigned w;
    if (a[31:16] != 16'h0) return 32'h0;
    w = int'(a[15:2]);
    if (model.exists(w)) return model[w];
    return 32'h0;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Drive one request, advance one clock, then check the registered outputs.
  task automatic op(input string tag, input logic rd, input logic [31:0] a, input logic [31:0] data);
    logic pending;
    read_en_i = rd;
    addr_i    = a;
    d_i       = data;
    pending   = rd && rst_ni;
    if (pending) exp_q.push_back(model_rd(a));
    else if (rst_ni && a[31:16] == 16'h0) model[int'(a[15:2])] = data;
    @(posedge clk_i);
    #1;
    if (pending) exp_d = exp_q.pop_front();
    else if (!rst_ni) exp_d = 32'h0;
    check1({tag, ".ready"}, ready_o, pending);
    check32({tag, ".d"}, d_o, exp_d);
  endtask

  initial begin
    rst_ni    = 1'b0;
    read_en_i = 1'b1;
    addr_i    = 32'hA5A5_0014;
    d_i       = 32'h1357_9BDF;

    // Reset held across edges with arbitrary inputs.
    @(posedge clk_i);
    #1;
    check32("rst.d", d_o, 32'h0);
    check1("rst.ready", ready_o, 1'b0);
    op("rst_rd", 1'b1, 32'h0000_0010, 32'h0);
    op("rst_wr", 1'b0, 32'h0000_0010, 32'h7777_7777);
    rst_ni = 1'b1;

    op("first_rd", 1'b1, 32'h0000_0000, 32'h0);
    op("wr10", 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    op("rd10", 1'b1, 32'h0000_0010, 32'h0);
    check32("rd10.const", d_o, 32'hDEAD_BEEF);
    op("wr_hold", 1'b0, 32'h0000_0014, 32'h0BAD_CAFE);
    op("wr20", 1'b0, 32'h0000_0020, 32'h1234_5678);
    op("rd23", 1'b1, 32'h0000_0023, 32'h0);
    check32("rd23.const", d_o, 32'h1234_5678);
    op("wrfffc", 1'b0, 32'h0000_FFFC, 32'hCAFE_F00D);
    op("rdfffc", 1'b1, 32'h0000_FFFC, 32'h0);
    check32("rdfffc.const", d_o, 32'hCAFE_F00D);
    op("wr_oor", 1'b0, 32'h0001_0000, 32'hFFFF_FFFF);
    op("rd_oor", 1'b1, 32'h0001_0000, 32'h0);
    check32("rd_oor.const", d_o, 32'h0);
    op("rd0_alias", 1'b1, 32'h0000_0000, 32'h0);
    check32("rd0_alias.const", d_o, 32'h0);
    op("rd14", 1'b1, 32'h0000_0014, 32'h0);

    for (int unsigned i = 0; i < 256; i++)
      op("stream_wr", 1'b0, i * 4, i);
    for (int unsigned i = 0; i < 256; i++)
      op("stream_rd", 1'b1, i * 4, 32'h0);
    check32("stream_last.const", d_o, 32'd255);

    // Asynchronous reset in the middle of a read burst.
    for (int unsigned i = 1; i < 9; i++)
      op("burst_rd", 1'b1, i * 4, 32'h0);
    #3;
    rst_ni = 1'b0;
    #1;
    check32("async_rst.d", d_o, 32'h0);
    check1("async_rst.ready", ready_o, 1'b0);
    op("burst_rd_in_rst", 1'b1, 32'h0000_0024, 32'h0);
    op("wr_in_rst", 1'b0, 32'h0000_0040, 32'hBAD0_BAD0);
    rst_ni = 1'b1;
    op("post_rst_rd40", 1'b1, 32'h0000_0040, 32'h0);
    check32("post_rst_rd40.const", d_o, 32'd16);
    op("post_rst_rd10", 1'b1, 32'h0000_0010, 32'h0);
    op("post_rst_rdfffc", 1'b1, 32'h0000_FFFC, 32'h0);
    op("post_rst_rd3fc", 1'b1, 32'h0000_03FC, 32'h0);

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
